// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the decode-stage hazard/forwarding controller
package pipe_pkg;
  localparam int NREG_DEF = 32;
  localparam int RN_W = $clog2(NREG_DEF);
  localparam logic [RN_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic            valid;
    logic            wreg;
    logic            m2reg;
    logic [RN_W-1:0] rn;
  } slot_t;
  function automatic bit load_ready_ok(int load_ready, int depth);
    return load_ready >= 0 && load_ready < depth;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctl_fwd_sel_n.sv
// fwd_sel_n: youngest-producer match and operand mux over the in-flight slots
//   slot_i: scoreboard, src_i/use_i: source register and whether it is read,
//   rf_i/stg_data_i: candidate data, data_o: operand, hit_o: a slot matched,
//   hazard_o: used operand whose producer has no data yet
module fwd_sel_n
  import pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_READY = 1
) (
  input  slot_t                     slot_i [FWD_DEPTH],
  input  logic [RN_W-1:0]           src_i,
  input  logic                      use_i,
  input  logic [XLEN-1:0]           rf_i,
  input  logic [FWD_DEPTH*XLEN-1:0] stg_data_i,
  output logic [XLEN-1:0]           data_o,
  output logic                      hit_o,
  output logic                      hazard_o
);
  logic ready;
  // Scan oldest to youngest so the lowest-index match overrides.
  always_comb begin
    data_o = rf_i;
    hit_o = 1'b0;
    ready = 1'b1;
    for (int k = FWD_DEPTH - 1; k >= 0; k--)
      if (slot_i[k].valid && slot_i[k].wreg && slot_i[k].rn == src_i && slot_i[k].rn != ZERO_REG) begin
        hit_o = 1'b1;
        ready = !slot_i[k].m2reg || k >= LOAD_READY;
        data_o = stg_data_i[k*XLEN +: XLEN];
      end
    hazard_o = use_i & hit_o & ~ready;
  end
endmodule

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: ID-stage scoreboard, operand forwarding, stall/issue and hazard counters
//   id_*_i: decoded ID instruction, flush_i: squash ID, rf_*_i: register file data,
//   stg_data_i: per-slot result buses, fwd_*_o: resolved operands,
//   stall_o/issue_o: pipeline control, stall_cnt_o/fwd_cnt_o: saturating counters
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NREG           = 32,
  parameter int FWD_DEPTH      = 3,
  parameter int LOAD_READY     = 1,
  parameter bit STORE_LATE_FWD = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [RN_W-1:0]           id_rs_i,
  input  logic [RN_W-1:0]           id_rt_i,
  input  logic                      id_use_rs_i,
  input  logic                      id_use_rt_i,
  input  logic                      id_wreg_i,
  input  logic                      id_m2reg_i,
  input  logic                      id_store_i,
  input  logic [RN_W-1:0]           id_rn_i,
  input  logic                      flush_i,
  input  logic [XLEN-1:0]           rf_a_i,
  input  logic [XLEN-1:0]           rf_b_i,
  input  logic [FWD_DEPTH*XLEN-1:0] stg_data_i,
  output logic [XLEN-1:0]           fwd_a_o,
  output logic [XLEN-1:0]           fwd_b_o,
  output logic                      stall_o,
  output logic                      issue_o,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               fwd_cnt_o
);
  if (!load_ready_ok(LOAD_READY, FWD_DEPTH)) begin : g_lr_chk
    $error("LOAD_READY must lie in [0, FWD_DEPTH)");
  end
  if ($clog2(NREG) != RN_W) begin : g_rn_chk
    $error("NREG does not match the register-number width");
  end
  slot_t slot_q [FWD_DEPTH];
  slot_t slot_d [FWD_DEPTH];
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic hit_a, hit_b, haz_a, haz_b, live;
  fwd_sel_n #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH), .LOAD_READY(LOAD_READY)) u_sel_a (
    .slot_i(slot_q), .src_i(id_rs_i), .use_i(id_use_rs_i), .rf_i(rf_a_i),
    .stg_data_i(stg_data_i), .data_o(fwd_a_o), .hit_o(hit_a), .hazard_o(haz_a)
  );
  // A store's rt is consumed late in MEM, so it may be forwarded after the load completes.
  fwd_sel_n #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH), .LOAD_READY(LOAD_READY)) u_sel_b (
    .slot_i(slot_q), .src_i(id_rt_i), .use_i(id_use_rt_i & ~(STORE_LATE_FWD & id_store_i)),
    .rf_i(rf_b_i), .stg_data_i(stg_data_i), .data_o(fwd_b_o), .hit_o(hit_b), .hazard_o(haz_b)
  );
  assign live = id_valid_i & ~flush_i;
  assign stall_o = live & (haz_a | haz_b);
  assign issue_o = live & ~stall_o;
  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o = fwd_cnt_q;
  always_comb begin
    slot_d[0] = issue_o ? slot_t'{valid: 1'b1, wreg: id_wreg_i, m2reg: id_m2reg_i, rn: id_rn_i} : '0;
    for (int k = 1; k < FWD_DEPTH; k++) slot_d[k] = slot_q[k-1];
    stall_cnt_d = (stall_o && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    fwd_cnt_d = (issue_o && ((id_use_rs_i && hit_a) || (id_use_rt_i && hit_b)) && fwd_cnt_q != '1) ? fwd_cnt_q + 32'd1 : fwd_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      slot_q <= '{default: '0};
      stall_cnt_q <= '0;
      fwd_cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
endmodule
